uart_recv: RTL and testbench

- Asynchronous 8N1 UART receiver that deserialises the RXD pin into bytes.
- Sits upstream of the command/data logic that drives uart_send, mirroring its DATA/DATA_READY/IDLE handshake.
- Fixed bit timing derived from a clocks-per-bit parameter.
- 3-sample majority vote per bit, false-start rejection, framing-error reporting.

---
 rtl/uart_recv.sv | 123 ++++++++++++
 tb/tb_uart_recv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote per bit, false-start rejection.
// Byte/frame-error pulses one cycle after the stop-bit vote; no backpressure, DATA holds until next good byte.
module uart_recv #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       DATA_READY,
    output logic       FRAME_ERR,
    output logic       IDLE
);

    localparam int C  = CLKS_PER_BIT;
    localparam int M  = C / 2;
    localparam int CW = $clog2(C);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(C - 1);
    localparam logic [CW-1:0] CNT_SM1  = CW'(M - 1);
    localparam logic [CW-1:0] CNT_SM   = CW'(M);
    localparam logic [CW-1:0] CNT_SP1  = CW'(M + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          r_sync1;
    logic          r_rxd_s;
    logic          r_rxd_prev;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic          r_s0;
    logic          r_s1;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_dv;
    logic          r_fe;

    logic          w_vote;
    logic          w_fall;

    // Third sample is the live synchronised value at offset M+1.
    assign w_vote = (r_s0 & r_s1) | (r_s0 & r_rxd_s) | (r_s1 & r_rxd_s);
    assign w_fall = ~r_rxd_s & r_rxd_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1    <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_shift    <= '0;
            r_data     <= '0;
            r_dv       <= 1'b0;
            r_fe       <= 1'b0;
        end else begin
            r_sync1    <= RXD;
            r_rxd_s    <= r_sync1;
            r_rxd_prev <= r_rxd_s;
            r_dv       <= 1'b0;
            r_fe       <= 1'b0;

            if (r_state != S_IDLE) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                if (r_cnt == CNT_SM1) r_s0 <= r_rxd_s;
                if (r_cnt == CNT_SM)  r_s1 <= r_rxd_s;
            end

            case (r_state)
                S_IDLE: begin
                    // Detection cycle counts as offset 0 of the start bit.
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_ONE;
                        r_bit   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_SP1 && w_vote) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_SP1) r_shift <= {w_vote, r_shift[7:1]};
                    if (r_cnt == CNT_LAST) begin
                        if (r_bit == 3'd7) r_state <= S_STOP;
                        else               r_bit   <= r_bit + 3'd1;
                    end
                end
                default: begin
                    // Leave half a bit early so a slightly fast sender's next start edge is seen.
                    if (r_cnt == CNT_SP1) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        if (w_vote) begin
                            r_data <= r_shift;
                            r_dv   <= 1'b1;
                        end else begin
                            r_fe   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign DATA       = r_data;
    assign DATA_READY = r_dv;
    assign FRAME_ERR  = r_fe;
    assign IDLE       = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: frames are driven bit by bit; each frame's expected pulse cycle, kind and
// DATA value are derived from the frame timing rules and checked by a negedge monitor.
module tb_uart_recv;

    localparam int C = 16;
    localparam int M = C / 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] DATA;
    logic       DATA_READY;
    logic       FRAME_ERR;
    logic       IDLE;

    uart_recv #(.CLKS_PER_BIT(C)) dut (
        .CLK(CLK), .RST(RST), .RXD(RXD),
        .DATA(DATA), .DATA_READY(DATA_READY), .FRAME_ERR(FRAME_ERR), .IDLE(IDLE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int cyc; bit err; logic [7:0] d; } ev_t;
    typedef struct { int cyc; bit is_data; logic [7:0] v; } probe_t;
    typedef struct { logic [7:0] d; bit stop; int gbit; int goff; } vec_t;

    ev_t        evq[$];
    probe_t     pq[$];
    logic [7:0] drv_data = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        ev_t ev;
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].cyc == cyc) begin
                if (pq[i].is_data) chk("probe_data", DATA, pq[i].v);
                else               chk("probe_idle", IDLE, pq[i].v);
                pq.delete(i);
            end
        end
        if (DATA_READY && FRAME_ERR) chk("pulse_exclusive", 1, 0);
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            chk("pulse_missing_at", 0, evq[0].cyc);
            void'(evq.pop_front());
        end
        if (DATA_READY || FRAME_ERR) begin
            if (evq.size() == 0 || evq[0].cyc != cyc) begin
                chk("unexpected_pulse_cycle", cyc, (evq.size() > 0) ? evq[0].cyc : -1);
            end else begin
                ev = evq.pop_front();
                chk("pulse_fe", FRAME_ERR, ev.err);
                chk("pulse_dr", DATA_READY, !ev.err);
                chk("pulse_data", DATA, ev.d);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_n(input int n);
        RXD = 1'b1;
        repeat (n) step();
    endtask

    // Sender bit offsets line up with the receiver's: the 2-cycle synchroniser delay equals T0 - k.
    task automatic send(input logic [7:0] d, input bit stop, input int gbit, input int goff,
                        input int abort_at);
        int k;
        logic [9:0] fr;
        k  = cyc;
        fr = {stop, d, 1'b0};
        if (abort_at < 0) begin
            evq.push_back('{k + 2 + 9*C + M + 2, !stop, stop ? d : drv_data});
            if (stop) drv_data = d;
        end
        for (int n = 0; n < 10; n++) begin
            for (int o = 0; o < C; o++) begin
                if (abort_at >= 0 && n*C + o == abort_at) begin
                    RST = 1'b1;
                    RXD = 1'b1;
                    pq.push_back('{cyc + 1, 1'b1, 8'h00});
                    pq.push_back('{cyc + 1, 1'b0, 8'h01});
                    step();
                    RST = 1'b0;
                    drv_data = 8'h00;
                    return;
                end
                RXD = fr[n] ^ (n == gbit && o == goff);
                step();
            end
        end
    endtask

    task automatic frame_idle_probes(input int t0);
        pq.push_back('{t0,                 1'b0, 8'h01});
        pq.push_back('{t0 + 1,             1'b0, 8'h00});
        pq.push_back('{t0 + 9*C + M + 1,   1'b0, 8'h00});
        pq.push_back('{t0 + 9*C + M + 2,   1'b0, 8'h01});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   t0;
        bit   prev_err;
        tbl[0] = '{8'h55, 1'b1, -1, 0};
        tbl[1] = '{8'hF0, 1'b1,  3, 8};
        tbl[2] = '{8'h00, 1'b1,  9, M + 1};
        tbl[3] = '{8'hFF, 1'b1,  0, M - 1};
        tbl[4] = '{8'h81, 1'b0, -1, 0};

        RST = 1'b1;
        RXD = 1'b1;
        repeat (3) step();
        chk("reset_data", DATA, 8'h00);
        chk("reset_idle", IDLE, 1);
        chk("reset_dr", DATA_READY, 0);
        chk("reset_fe", FRAME_ERR, 0);
        RST = 1'b0;
        idle_n(5);

        for (int i = 0; i < 5; i++) begin
            frame_idle_probes(cyc + 2);
            send(tbl[i].d, tbl[i].stop, tbl[i].gbit, tbl[i].goff, -1);
            idle_n(3);
        end

        for (int i = 0; i < 10; i++) send(8'h30 + 8'(i), 1'b1, -1, 0, -1);
        idle_n(3);

        t0 = cyc + 2;
        pq.push_back('{t0 + 1,  1'b0, 8'h00});
        pq.push_back('{t0 + 9,  1'b0, 8'h00});
        pq.push_back('{t0 + 10, 1'b0, 8'h01});
        pq.push_back('{t0 + 10, 1'b1, drv_data});
        RXD = 1'b0;
        repeat (3) step();
        idle_n(20);

        frame_idle_probes(cyc + 2);
        send(8'hA5, 1'b0, -1, 0, -1);
        RXD = 1'b0;
        repeat (40) step();
        idle_n(5);
        send(8'h3C, 1'b1, -1, 0, -1);
        idle_n(5);

        send(8'hC3, 1'b1, -1, 0, 5*C + 4);
        idle_n(5);
        send(8'h0F, 1'b1, -1, 0, -1);

        prev_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            bit         stop;
            int         gbit;
            int         goff;
            int         gap;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            gbit = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, stop ? 9 : 8));
            goff = M - 1 + int'($urandom_range(0, 2));
            gap  = prev_err ? int'($urandom_range(2, 4)) : int'($urandom_range(0, 3));
            if (gap > 0) idle_n(gap);
            send(d, stop, gbit, goff, -1);
            prev_err = !stop;
        end

        idle_n(3*C);
        chk("pending_events", evq.size(), 0);
        chk("pending_probes", pq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
